// File: rtl/pid_pkg.sv
// Shared widths, D-source selector and the signed saturation helper used by
// the pipelined PID controller and its integrator.
package pid_pkg;

    localparam int DEF_IN_W    = 16;
    localparam int DEF_ERR_W   = 10;
    localparam int DEF_INT_W   = 18;
    localparam int DEF_OUT_W   = 12;
    localparam int DEF_KP_W    = 5;
    localparam int DEF_I_SHIFT = 6;
    localparam int DEF_D_SHIFT = 6;
    localparam int DEF_SS_W    = 27;

    typedef enum logic {
        D_EXT  = 1'b0,
        D_DIFF = 1'b1
    } d_mode_e;

    // Clamp a wide signed value into the range of a signed 'width'-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                                 input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/pid_sat_integrator.sv
// Clamping error accumulator: clears on clr, skips the update while frozen,
// and saturates at the signed INT_W limits instead of wrapping.
module pid_sat_integrator
    import pid_pkg::*;
#(
    parameter int ERR_W = DEF_ERR_W,
    parameter int INT_W = DEF_INT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ERR_W-1:0] err,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    freeze,
    output logic signed [INT_W-1:0] integ
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            integ <= '0;
        else if (clr)
            integ <= '0;
        else if (en && !freeze)
            integ <= INT_W'(sat_s(64'(integ) + 64'(err), INT_W));
    end

endmodule

// File: rtl/pid_ctrl_pipe.sv
// Pipelined balance PID: saturated error, programmable P gain, selectable D
// source, clamped integrator with anti-windup, registered saturated output.
module pid_ctrl_pipe
    import pid_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int INT_W    = DEF_INT_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int KP_W     = DEF_KP_W,
    parameter int I_SHIFT  = DEF_I_SHIFT,
    parameter int D_SHIFT  = DEF_D_SHIFT,
    parameter int D_MODE   = 0,
    parameter int SS_W     = DEF_SS_W,
    parameter int fast_sim = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld,
    input  logic signed [IN_W-1:0] ptch,
    input  logic signed [IN_W-1:0] ptch_rt,
    input  logic [KP_W-1:0]        kp,
    input  logic                   pwr_up,
    input  logic                   rider_off,
    output logic signed [OUT_W-1:0] PID_cntrl,
    output logic                   cntrl_vld,
    output logic                   sat_flag,
    output logic [7:0]             ss_tmr
);

    // Flow control: no backpressure. Every cycle with vld=1 is one sample;
    // each sample yields exactly one cntrl_vld pulse two clock edges later.

    localparam int P_W   = ERR_W + KP_W + 1;
    localparam int D_W   = IN_W + 2;
    localparam int SUM_W = IN_W + INT_W + 2;
    localparam d_mode_e D_SEL = (D_MODE != 0) ? D_DIFF : D_EXT;
    localparam logic [SS_W-1:0] TMR_INC = (fast_sim != 0) ? SS_W'(256) : SS_W'(1);

    logic signed [ERR_W-1:0] err;
    logic signed [ERR_W-1:0] err_prev;
    logic signed [P_W-1:0]   p_prod;
    logic signed [P_W-1:0]   p_q;
    logic signed [D_W-1:0]   d_val;
    logic signed [D_W-1:0]   d_q;
    logic signed [INT_W-1:0] integ;
    logic signed [SUM_W-1:0] sum_q;
    logic                    v1;
    logic                    v2;
    logic                    freeze;
    logic [SS_W-1:0]         ss_cnt;

    always_comb begin
        err    = ERR_W'(sat_s(64'(ptch), ERR_W));
        p_prod = P_W'(err) * P_W'($signed({1'b0, kp}));
        if (D_SEL == D_DIFF)
            d_val = -(D_W'(err) - D_W'(err_prev));
        else
            d_val = -D_W'(ptch_rt >>> D_SHIFT);
        // Stop winding further into a saturation the output is already pinned at.
        freeze = sat_flag && (err[ERR_W-1] == PID_cntrl[OUT_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            p_q      <= '0;
            d_q      <= '0;
            err_prev <= '0;
        end else begin
            v1 <= vld;
            if (vld) begin
                p_q <= p_prod;
                d_q <= d_val;
            end
            if (rider_off)
                err_prev <= '0;
            else if (vld)
                err_prev <= err;
        end
    end

    pid_sat_integrator #(
        .ERR_W(ERR_W),
        .INT_W(INT_W)
    ) u_integ (
        .clk   (clk),
        .rst_n (rst_n),
        .err   (err),
        .en    (vld),
        .clr   (rider_off),
        .freeze(freeze),
        .integ (integ)
    );

    // The integrator read here is the value stage 1 wrote for this sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sum_q <= '0;
        end else begin
            v2 <= v1;
            if (v1)
                sum_q <= SUM_W'(p_q) + SUM_W'(integ >>> I_SHIFT) + SUM_W'(d_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntrl_vld <= 1'b0;
            PID_cntrl <= '0;
            sat_flag  <= 1'b0;
        end else begin
            cntrl_vld <= v2;
            if (v2) begin
                PID_cntrl <= OUT_W'(sat_s(64'(sum_q), OUT_W));
                sat_flag  <= (sat_s(64'(sum_q), OUT_W) != 64'(sum_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ss_cnt <= '0;
        else if (!pwr_up)
            ss_cnt <= '0;
        else if (!(&ss_cnt[SS_W-1:8]))
            ss_cnt <= ss_cnt + TMR_INC;
    end

    assign ss_tmr = ss_cnt[SS_W-1:SS_W-8];

endmodule

// File: doc/pid_ctrl_pipe.md
Name: pid_ctrl_pipe

Overview:
Parametrised, pipelined successor of the balance PID controller. It takes a pitch error and a pitch rate and produces a saturated signed steering/drive control word together with a valid strobe. Compared with the current PID it adds:
- a runtime-programmable P gain;
- a selectable D source (external rate, or an internal sample difference);
- clamping integrator with conditional anti-windup;
- registered output, fixed latency and an output-valid strobe.

It sits between the inertial interface and the motor-balance block, and also supplies the soft-start timer.

Parameters:
IN_W, 16, width of ptch / ptch_rt inputs (signed)
ERR_W, 10, saturated error width (signed)
INT_W, 18, integrator width (signed)
OUT_W, 12, PID_cntrl width (signed)
KP_W, 5, width of kp input (unsigned magnitude)
I_SHIFT, 6, integrator arithmetic right shift for I term
D_SHIFT, 6, rate arithmetic right shift for D term
D_MODE, 0, 0 = D from ptch_rt input; 1 = D from ptch_err_sat(n) minus ptch_err_sat(n-1)
SS_W, 27, soft-start counter width
fast_sim, 0, 1 = soft-start increment of 256, else 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld  in  1  new sensor sample on ptch/ptch_rt this cycle
ptch  in  IN_W  signed pitch error
ptch_rt  in  IN_W  signed pitch rate (ignored when D_MODE=1)
kp  in  KP_W  unsigned proportional gain; sampled with vld
pwr_up  in  1  0 holds soft-start counter at 0
rider_off  in  1  clears integrator and D history
PID_cntrl  out  OUT_W  signed saturated control, registered
cntrl_vld  out  1  one-cycle pulse, PID_cntrl updated
sat_flag  out  1  last output was saturated (registered with PID_cntrl)
ss_tmr  out  8  soft-start ramp, top 8 bits of counter

Behaviour:
- Reset (async, rst_n=0): all registers cleared.
  - PID_cntrl=0, cntrl_vld=0, sat_flag=0, ss_tmr=0.
  - Integrator=0, D history=0, pipeline valids=0.
- Error saturation: ptch is saturated to a signed ERR_W value (err).
  - Range is -2^(ERR_W-1) to 2^(ERR_W-1)-1 (e.g. 0x200..0x1FF).
- Stage 1, on the clock edge where vld=1:
  - Register err, P = err * kp, computed signed with kp zero-extended.
  - Register D as follows:
    - D_MODE=0: D = -(ptch_rt >>> D_SHIFT), true two's-complement negate.
    - D_MODE=1: D = -(err - err_prev); err_prev <= err.
  - Integrator update, when rider_off=0:
    - I_next = integrator + sign-extended err.
    - I_next clamps to INT_W signed max/min; it never wraps and never holds on overflow.
  - Anti-windup: the integrator is not updated when sat_flag=1 and err has the same sign as the current PID_cntrl.
  - Set v1=1; v1 is 0 on any cycle where vld=0.
- Stage 2, cycle after v1=1:
  - sum = P + (integrator >>> I_SHIFT) + D, computed at full width with no intermediate overflow.
  - The integrator value used is the one just written by stage 1.
  - PID_cntrl <= sum saturated to OUT_W (0x7FF / 0x800 at default widths).
  - sat_flag <= (saturation occurred); cntrl_vld <= 1 for exactly one cycle.
- Latency: vld at edge n -> PID_cntrl/cntrl_vld at edge n+2. Back-to-back vld is allowed, with throughput one sample per clock.
- PID_cntrl holds its value between updates.
- rider_off=1 (any cycle):
  - Integrator <= 0 and err_prev <= 0, with priority over a same-cycle vld accumulation.
  - The pipeline still produces output for that sample, using integrator=0.
- Soft start:
  - pwr_up=0: counter <= 0.
  - Otherwise the counter increments by TMR_INC (256 if fast_sim else 1) until bits [SS_W-1:8] are all ones, then holds.
  - ss_tmr = counter[SS_W-1:SS_W-8].
  - The counter is independent of vld.
- Reset mid-pipeline: in-flight samples are discarded and no cntrl_vld is issued.

Decomposition:
- Package pid_pkg holds:
  - signed saturation function sat_s(value, width);
  - default width localparams;
  - d_mode_e enum (D_EXT, D_DIFF).
- One sub-module: pid_sat_integrator. It contains the clamped accumulator, rider_off clear and anti-windup gate; I/O are err, en, clr, freeze and integ.
- The soft-start counter stays inline.

Test Plan:
- ptch=100, ptch_rt=0, kp=12, D_MODE=0, integrator 0, one vld pulse -> at n+2: PID_cntrl=1201 (1200+1+0), cntrl_vld=1 for one cycle, sat_flag=0.
- ptch=16'h0400 (err saturates to 511), kp=12 -> PID_cntrl=0x7FF, sat_flag=1.
  - Next vld with the same ptch: integrator unchanged (anti-windup).
  - Then ptch=-50: integrator decreases by 50.
- ptch=16'h8000, 600 consecutive vld with kp=0 and sat_flag forced clear by a small kp window -> integrator clamps at -131072 and does not wrap positive.
  - Separately check positive clamp at 131071.
- D_MODE=1, ptch samples 0 then 64, kp=0, rider_off pulse first -> second output D = -64, PID_cntrl = -64 + I term (64>>>6 = 1) = -63.
- pwr_up=1, fast_sim=1 -> ss_tmr reaches 0xFF and holds.
  - Drop pwr_up -> ss_tmr=0 next cycle.
  - Assert rst_n=0 between vld and cntrl_vld -> no cntrl_vld, PID_cntrl=0.
